// File: rtl/mem_lsu_ctrl.sv
// Memory-stage load/store controller: one access per M-stage instruction over a req/ack data bus.
// Latency: request sampled in IDLE, bus_req next cycle, result pulse the cycle after bus_ack (minimum 2 stall cycles).
// Backpressure: stall holds the pipeline while the bus is busy; a flushed access drains silently before IDLE.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_op/req_addr/req_wdata : M-stage access; req_op = {store, unsigned, size[1:0]}
//   flush                                : kill the current access
//   stall                                : hold F/D/E/M pipeline registers
//   resp_valid/resp_rdata                : one-cycle completion pulse with extended load data
//   exc_valid/exc_code                   : one-cycle fault pulse (4=AdEL, 5=AdES, 7=DBE)
//   bus_req/bus_we/bus_addr/bus_wdata/bus_byteen : registered bus request, stable during BUSY
//   bus_ack/bus_err/bus_rdata            : bus completion, failure and read data
module mem_lsu_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                flush,
  output logic                stall,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                exc_valid,
  output logic [4:0]          exc_code,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_byteen,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int L  = DATA_W / 8;
  localparam int LW = $clog2(L);

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_q;
  logic [LW-1:0]     lane_q;
  logic [2:0]        op_q;

  logic [LW-1:0]     lane;
  logic [1:0]        size;
  logic              misaligned;
  logic [L-1:0]      be_d;
  logic [DATA_W-1:0] wd_d;
  logic [DATA_W-1:0] rsh;
  logic [DATA_W-1:0] ext;
  logic              to_hit;
  logic              bus_end;

  logic              start;
  logic              fin_ok;
  logic              fin_exc;
  logic [4:0]        code_d;
  logic              drop_req;

  assign lane = req_addr[LW-1:0];
  assign size = req_op[1:0];

  // A dword access cannot exist on a 32-bit bus, so it always faults there.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lane[0];
      2'd2:    misaligned = |lane[1:0];
      default: misaligned = (DATA_W == 32) || (|lane);
    endcase
  end

  always_comb begin
    be_d = '1;
    wd_d = req_wdata;
    case (size)
      2'd0: begin
        be_d = L'(1) << lane;
        wd_d = {(DATA_W/8){req_wdata[7:0]}};
      end
      2'd1: begin
        be_d = L'(3) << lane;
        wd_d = {(DATA_W/16){req_wdata[15:0]}};
      end
      2'd2: begin
        be_d = L'(15) << lane;
        wd_d = {(DATA_W/32){req_wdata[31:0]}};
      end
      default: begin
        be_d = '1;
        wd_d = req_wdata;
      end
    endcase
  end

  // Load data is aligned to bit 0 using the lane captured at request time.
  assign rsh = bus_rdata >> {lane_q, 3'b000};

  always_comb begin
    ext = rsh;
    case (op_q[1:0])
      2'd0: begin
        if (op_q[2]) ext = DATA_W'(rsh[7:0]);
        else         ext = DATA_W'($signed(rsh[7:0]));
      end
      2'd1: begin
        if (op_q[2]) ext = DATA_W'(rsh[15:0]);
        else         ext = DATA_W'($signed(rsh[15:0]));
      end
      2'd2: begin
        if (op_q[2]) ext = DATA_W'(rsh[31:0]);
        else         ext = DATA_W'($signed(rsh[31:0]));
      end
      default: ext = rsh;
    endcase
  end

  // to_q is 0 in the first BUSY cycle, so the TIMEOUT-th waiting cycle is the last.
  assign to_hit  = (to_q == TO_W'(TIMEOUT - 1));
  assign bus_end = bus_err | bus_ack | to_hit;

  assign stall = ((state_q == IDLE) & req_valid & ~flush) |
                 (state_q == BUSY) | (state_q == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    fin_ok   = 1'b0;
    fin_exc  = 1'b0;
    code_d   = 5'd0;
    drop_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          if (misaligned) begin
            state_d = DONE;
            fin_exc = 1'b1;
            code_d  = req_op[3] ? EXC_ADES : EXC_ADEL;
          end else begin
            state_d = BUSY;
            start   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          // A killed access still has to finish on the bus before we can reuse it.
          if (bus_end) begin
            state_d  = IDLE;
            drop_req = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else if (bus_err) begin
          state_d  = DONE;
          fin_exc  = 1'b1;
          code_d   = EXC_DBE;
          drop_req = 1'b1;
        end else if (bus_ack) begin
          state_d  = DONE;
          fin_ok   = 1'b1;
          drop_req = 1'b1;
        end else if (to_hit) begin
          state_d  = DONE;
          fin_exc  = 1'b1;
          code_d   = EXC_DBE;
          drop_req = 1'b1;
        end
      end
      DRAIN: begin
        if (bus_end) begin
          state_d  = IDLE;
          drop_req = 1'b1;
        end
      end
      // The request visible during DONE is the instruction being retired.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      exc_valid  <= 1'b0;
      exc_code   <= 5'd0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_byteen <= '0;
      to_q       <= '0;
      lane_q     <= '0;
      op_q       <= '0;
    end else begin
      resp_valid <= fin_ok;
      exc_valid  <= fin_exc;
      exc_code   <= fin_exc ? code_d : 5'd0;
      if (fin_ok) resp_rdata <= ext;
      if (start) begin
        bus_req    <= 1'b1;
        bus_we     <= req_op[3];
        bus_addr   <= req_addr & ~ADDR_W'(L - 1);
        bus_wdata  <= wd_d;
        bus_byteen <= be_d;
        lane_q     <= lane;
        op_q       <= req_op[2:0];
        to_q       <= '0;
      end else begin
        if (drop_req) bus_req <= 1'b0;
        if (state_q == BUSY || state_q == DRAIN) to_q <= to_q + TO_W'(1);
      end
    end
  end

endmodule
